uart_rx: RTL and testbench

- Serial UART receiver for frames of 1 start bit, DATA_BITS data bits (LSB first), optional parity and 1 stop bit.
- Consumes the 16x oversampling pulse (sample_tick) from the baud generator and centre-samples each bit.
- Delivers each received word with error flags through a valid/ready holding register to the host side.
- Receive-side counterpart of the UART transmitter; shares the same baud generator.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encoding and oversampling constants.
// Used by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] MID_TICK   = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Resets to 1 so that a line held idle does not look like a start bit.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the async input through two flops.
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, centre-sampled, LSB-first frames with
// optional parity; words leave through a valid/ready holding register.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_tick,
   input  logic                 rx,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic       HAS_PAR  = (PARITY_EN != 0);
   localparam logic       ODD      = (PARITY_ODD != 0);

   logic                 rx_s;
   rx_state_t            state, state_n;
   logic [3:0]           tick_cnt, tick_cnt_n;
   logic [2:0]           bit_cnt, bit_cnt_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 par_bit, par_bit_n;
   logic                 done;
   logic                 perr;

   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   // Frame state, counters and shift register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_cnt_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         par_bit  <= par_bit_n;
      end
   end

   // Next-state logic; everything advances only on sample ticks.
   always_comb begin
      state_n    = state;
      tick_cnt_n = tick_cnt;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      par_bit_n  = par_bit;
      done       = 1'b0;
      if (sample_tick) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_n    = START;
                  tick_cnt_n = '0;
               end
            end
            START: begin
               if (tick_cnt == MID_TICK) begin
                  tick_cnt_n = '0;
                  bit_cnt_n  = '0;
                  state_n    = rx_s ? IDLE : DATA;
               end else begin
                  tick_cnt_n = tick_cnt + 4'd1;
               end
            end
            DATA: begin
               if (tick_cnt == LAST_TICK) begin
                  shreg_n    = {rx_s, shreg[DATA_BITS-1:1]};
                  tick_cnt_n = '0;
                  bit_cnt_n  = bit_cnt + 3'd1;
                  if (bit_cnt == LAST_BIT)
                     state_n = HAS_PAR ? PARITY : STOP;
               end else begin
                  tick_cnt_n = tick_cnt + 4'd1;
               end
            end
            PARITY: begin
               if (tick_cnt == LAST_TICK) begin
                  par_bit_n  = rx_s;
                  tick_cnt_n = '0;
                  state_n    = STOP;
               end else begin
                  tick_cnt_n = tick_cnt + 4'd1;
               end
            end
            STOP: begin
               if (tick_cnt == LAST_TICK) begin
                  done       = 1'b1;
                  tick_cnt_n = '0;
                  state_n    = rx_s ? IDLE : WAIT_HIGH;
               end else begin
                  tick_cnt_n = tick_cnt + 4'd1;
               end
            end
            WAIT_HIGH: begin
               if (rx_s)
                  state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign perr = HAS_PAR && ((^shreg ^ par_bit) != ODD);
   assign busy = (state != IDLE);

   // Holding register: load on completion unless a word is still unclaimed.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shreg;
               frame_err  <= ~rx_s;
               parity_err <= perr;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance driven by
// directed and random frames, checked against a frame-level model.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] tdiv = 2'd0;
   logic       sample_tick;
   logic       rx0 = 1'b1;
   logic       rx1 = 1'b1;
   logic       rdy = 1'b1;

   logic [7:0] d0, d1;
   logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;

   int n_assert = 0;
   int n_fail   = 0;
   int ovc0     = 0;
   int vcyc0    = 0;

   logic [9:0] q0[$];
   logic [9:0] q1[$];

   always #5 clk = ~clk;

   always @(posedge clk) tdiv <= tdiv + 2'd1;
   assign sample_tick = (tdiv == 2'd3);

   uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
      .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx0),
      .rx_ready(rdy), .rx_data(d0), .rx_valid(v0), .frame_err(fe0),
      .parity_err(pe0), .overrun(ov0), .busy(b0)
   );

   uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
      .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx1),
      .rx_ready(rdy), .rx_data(d1), .rx_valid(v1), .frame_err(fe1),
      .parity_err(pe1), .overrun(ov1), .busy(b1)
   );

   always @(negedge clk) begin
      if (reset) begin
         if (v0 && rdy) q0.push_back({fe0, pe0, d0});
         if (v1 && rdy) q1.push_back({fe1, pe1, d1});
         if (ov0) ovc0++;
         if (v0) vcyc0++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int w, input logic v, input int n);
      if (w == 0) rx0 = v;
      else rx1 = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int w, input logic [7:0] d, input logic pb,
                       input logic sb, input int stop_len);
      drive(w, 1'b0, 64);
      for (int i = 0; i < 8; i++) drive(w, d[i], 64);
      if (w == 1) drive(w, pb, 64);
      drive(w, sb, 64 * stop_len);
      drive(w, 1'b1, 128);
   endtask

   task automatic expect_word(input int w, input logic [7:0] d,
                              input logic fe, input logic pe,
                              input string tag);
      int         n;
      logic [9:0] e;
      n = (w == 0) ? q0.size() : q1.size();
      chk({tag, " count"}, n, 1);
      if (n > 0) begin
         if (w == 0) e = q0.pop_front();
         else e = q1.pop_front();
         chk({tag, " data"}, e[7:0], d);
         chk({tag, " frame_err"}, e[9], fe);
         chk({tag, " parity_err"}, e[8], pe);
      end
      if (w == 0) q0 = {};
      else q1 = {};
   endtask

   function automatic logic model_perr(input int w, input logic [7:0] d,
                                       input logic pb);
      int ones = 0;
      if (w == 0) return 1'b0;
      for (int i = 0; i < 8; i++) ones += d[i];
      return ((ones + pb) % 2) != 0;
   endfunction

   task automatic reset_checks(input string tag);
      chk({tag, " data0"}, d0, 0);
      chk({tag, " valid0"}, v0, 0);
      chk({tag, " fe0"}, fe0, 0);
      chk({tag, " pe0"}, pe0, 0);
      chk({tag, " ov0"}, ov0, 0);
      chk({tag, " busy0"}, b0, 0);
      chk({tag, " valid1"}, v1, 0);
      chk({tag, " busy1"}, b1, 0);
      chk({tag, " ov1"}, ov1, 0);
   endtask

   initial begin
      int         base;
      int         w;
      logic [7:0] d;
      logic       pb, sb;

      repeat (5) @(posedge clk);
      #1;
      reset_checks("reset");
      reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      base = vcyc0;
      send(0, 8'hA5, 1'b0, 1'b1, 1);
      expect_word(0, 8'hA5, 1'b0, 1'b0, "a5");
      chk("a5 valid cycles", vcyc0 - base, 1);
      chk("a5 busy after", b0, 0);

      drive(0, 1'b0, 12);
      chk("glitch busy", b0, 1);
      drive(0, 1'b0, 8);
      drive(0, 1'b1, 128);
      chk("glitch no word", q0.size(), 0);
      chk("glitch busy end", b0, 0);

      send(1, 8'h07, 1'b1, 1'b1, 1);
      expect_word(1, 8'h07, 1'b0, 1'b0, "par ok");
      send(1, 8'h07, 1'b0, 1'b1, 1);
      expect_word(1, 8'h07, 1'b0, 1'b1, "par bad");

      send(0, 8'h3C, 1'b0, 1'b0, 3);
      expect_word(0, 8'h3C, 1'b1, 1'b0, "break");
      send(0, 8'h55, 1'b0, 1'b1, 1);
      expect_word(0, 8'h55, 1'b0, 1'b0, "after break");

      rdy  = 1'b0;
      base = ovc0;
      send(0, 8'h11, 1'b0, 1'b1, 1);
      send(0, 8'h22, 1'b0, 1'b1, 1);
      chk("ovr valid held", v0, 1);
      chk("ovr data held", d0, 8'h11);
      chk("ovr pulses", ovc0 - base, 1);
      rdy = 1'b1;
      @(posedge clk);
      #1;
      chk("ovr valid drop", v0, 0);
      expect_word(0, 8'h11, 1'b0, 1'b0, "ovr accepted");

      drive(0, 1'b0, 64);
      drive(0, 1'b1, 3 * 64 + 32);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_checks("midreset");
      reset = 1'b1;
      drive(0, 1'b1, 6 * 64);
      send(0, 8'h81, 1'b0, 1'b1, 1);
      expect_word(0, 8'h81, 1'b0, 1'b0, "post reset");

      for (int i = 0; i < 12; i++) begin
         w  = i % 2;
         d  = 8'($urandom);
         pb = 1'($urandom);
         sb = ($urandom_range(0, 3) != 0);
         send(w, d, pb, sb, 1);
         expect_word(w, d, ~sb, model_perr(w, d, pb), "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
